// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - cache main bus request/snoop/response bundle between initiator and memory responder
interface mem_bus_responder_if #(
    parameter int ADDRESSWIDTH = 16,
    parameter int DATABUSWIDTH = 32,
    parameter int BLOCKBYTES   = 4
);
    logic                    req_valid;
    logic                    req_read;
    logic [ADDRESSWIDTH-1:0] req_addr;
    logic [DATABUSWIDTH-1:0] req_wdata;
    logic [BLOCKBYTES-1:0]   req_byteen;
    logic                    req_ready;
    logic                    snoop_shared;
    logic                    snoop_flush;
    logic [DATABUSWIDTH-1:0] snoop_data;
    logic                    rsp_valid;
    logic [DATABUSWIDTH-1:0] rsp_data;
    logic                    rsp_shared;
    logic                    rsp_src;

    modport master (
        output req_valid, req_read, req_addr, req_wdata, req_byteen,
        output snoop_shared, snoop_flush, snoop_data,
        input  req_ready, rsp_valid, rsp_data, rsp_shared, rsp_src
    );

    modport slave (
        input  req_valid, req_read, req_addr, req_wdata, req_byteen,
        input  snoop_shared, snoop_flush, snoop_data,
        output req_ready, rsp_valid, rsp_data, rsp_shared, rsp_src
    );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder with snoop window, cache intervention and write-through ack
module mem_bus_responder #(
    parameter int ADDRESSWIDTH  = 16,
    parameter int DATABUSWIDTH  = 32,
    parameter int BLOCKBYTES    = 4,
    parameter int READ_LATENCY  = 4,
    parameter int SNOOP_CYCLES  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    mem_bus_responder_if.slave  bus_io
);
    localparam int IDXW  = ADDRESSWIDTH - 2;
    localparam int WORDS = 2 ** IDXW;
    localparam logic [7:0] SNOOP_LAST = 8'(SNOOP_CYCLES - 1);
    localparam logic [7:0] READ_LAST  = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WRITE_LAST = 8'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_WAIT,
        S_RESP,
        S_WRITE
    } state_t;

    logic [DATABUSWIDTH-1:0] mem_q [WORDS];

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [IDXW-1:0]         idx_q;
    logic                    shared_f_q;
    logic                    flush_f_q;
    logic [DATABUSWIDTH-1:0] flush_data_q;
    logic [DATABUSWIDTH-1:0] wmerged_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [DATABUSWIDTH-1:0] rsp_data_q;
    logic                    rsp_shared_q;
    logic                    rsp_src_q;

    logic                    accept;
    logic [IDXW-1:0]         req_idx;
    logic [DATABUSWIDTH-1:0] cur_word;
    logic [DATABUSWIDTH-1:0] merged_d;
    logic                    shared_in;
    logic                    flush_in;
    logic                    snoop_end;
    logic                    mem_we;
    logic [IDXW-1:0]         mem_widx;
    logic [DATABUSWIDTH-1:0] mem_wdata;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^bus_io.req_addr[1:0];

    always_comb begin
        accept    = (state_q == S_IDLE) && bus_io.req_valid;
        req_idx   = bus_io.req_addr[ADDRESSWIDTH-1:2];
        cur_word  = mem_q[req_idx];
        merged_d  = cur_word;
        for (int k = 0; k < BLOCKBYTES; k++) begin
            if (bus_io.req_byteen[k]) begin
                merged_d[8*k +: 8] = bus_io.req_wdata[8*k +: 8];
            end
        end
        // Snoop lines are wired-OR with pull-ups absent; only a driven 1 counts.
        shared_in = (bus_io.snoop_shared === 1'b1);
        flush_in  = (bus_io.snoop_flush === 1'b1);
        snoop_end = (state_q == S_SNOOP) && (cnt_q == SNOOP_LAST);
        mem_widx  = (state_q == S_IDLE) ? req_idx : idx_q;
        mem_wdata = (state_q == S_IDLE) ? merged_d
                  : (flush_f_q ? flush_data_q : bus_io.snoop_data);
        // Gating with rst_ni keeps an abandoned transaction out of the array.
        mem_we    = rst_ni && ((accept && !bus_io.req_read)
                             || (snoop_end && (flush_f_q || flush_in)));
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shared_f_q   <= 1'b0;
            flush_f_q    <= 1'b0;
            flush_data_q <= '0;
            wmerged_q    <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_shared_q <= 1'b0;
            rsp_src_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        idx_q       <= req_idx;
                        shared_f_q  <= 1'b0;
                        flush_f_q   <= 1'b0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (bus_io.req_read) begin
                            state_q <= S_SNOOP;
                        end else begin
                            wmerged_q <= merged_d;
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_SNOOP: begin
                    cnt_q      <= cnt_q + 8'd1;
                    shared_f_q <= shared_f_q | shared_in;
                    if (flush_in && !flush_f_q) begin
                        flush_f_q    <= 1'b1;
                        flush_data_q <= bus_io.snoop_data;
                    end
                    if (snoop_end) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // An intervention responds one cycle after the window closes.
                    if (flush_f_q) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= flush_data_q;
                        rsp_shared_q <= shared_f_q;
                        rsp_src_q    <= 1'b1;
                    end else if (cnt_q == READ_LAST) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= mem_q[idx_q];
                        rsp_shared_q <= shared_f_q;
                        rsp_src_q    <= 1'b0;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                S_WRITE: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == WRITE_LAST) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= wmerged_q;
                        rsp_shared_q <= 1'b0;
                        rsp_src_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus_io.req_ready  = req_ready_q;
    assign bus_io.rsp_valid  = rsp_valid_q;
    assign bus_io.rsp_data   = rsp_data_q;
    assign bus_io.rsp_shared = rsp_shared_q;
    assign bus_io.rsp_src    = rsp_src_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - table-driven scoreboard bench for mem_bus_responder
module tb_mem_bus_responder;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    mem_bus_responder_if bus ();

    mem_bus_responder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  sh;
        logic [1:0]  fl;
        logic [31:0] fd1;
        logic [31:0] fd2;
        logic [31:0] exp_data;
        logic        exp_sh;
        logic        exp_src;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        sh;
        logic        src;
        int          at;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 data=%h at cycle %0d, required no response", bus.rsp_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rsp_data !== e.data || bus.rsp_shared !== e.sh
                    || bus.rsp_src !== e.src || cyc != e.at) begin
                    failures++;
                    $display("FAIL rsp: got data=%h shared=%b src=%b cycle=%0d, required data=%h shared=%b src=%b cycle=%0d",
                             bus.rsp_data, bus.rsp_shared, bus.rsp_src, cyc, e.data, e.sh, e.src, e.at);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got req_ready=0, required 1");
        end
    endtask

    task automatic idle_bus();
        bus.req_valid    = 1'b0;
        bus.req_read     = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_byteen   = '0;
        bus.snoop_shared = 1'bz;
        bus.snoop_flush  = 1'b0;
        bus.snoop_data   = '0;
    endtask

    task automatic do_txn(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_read   = v.rd;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_byteen = v.be;
        wait_ready();
        e.data = v.exp_data;
        e.sh   = v.exp_sh;
        e.src  = v.exp_src;
        e.at   = cyc + 1 + v.exp_lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (v.rd) begin
            bus.snoop_shared = v.sh[0] ? 1'b1 : 1'bz;
            bus.snoop_flush  = v.fl[0];
            bus.snoop_data   = v.fd1;
            @(posedge clk);
            #1;
            bus.snoop_shared = v.sh[1] ? 1'b1 : 1'bz;
            bus.snoop_flush  = v.fl[1];
            bus.snoop_data   = v.fd2;
            @(posedge clk);
            #1;
            bus.snoop_shared = 1'bz;
            bus.snoop_flush  = 1'b0;
            bus.snoop_data   = '0;
        end
        wait_drain();
    endtask

    function automatic vec_t mk(input logic rd, input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [1:0] sh, input logic [1:0] fl,
                                input logic [31:0] fd1, input logic [31:0] fd2,
                                input logic [31:0] ed, input logic es, input logic esrc, input int lat);
        vec_t v;
        v.rd = rd; v.addr = addr; v.wdata = wdata; v.be = be; v.sh = sh; v.fl = fl;
        v.fd1 = fd1; v.fd2 = fd2; v.exp_data = ed; v.exp_sh = es; v.exp_src = esrc; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        idle_bus();

        // read request held throughout reset must not be accepted
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b1;
        bus.req_addr  = 16'h0504;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("reset_req_ready", bus.req_ready, 1'b1);
            check_bit("reset_rsp_valid", bus.rsp_valid, 1'b0);
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_bit("post_reset_req_ready", bus.req_ready, 1'b1);
        check_bit("post_reset_rsp_src", bus.rsp_src, 1'b0);

        //          rd   addr      wdata         be       sh     fl     fd1           fd2           exp_data      sh    src  lat
        vecs[0]  = mk(0, 16'h0504, 32'hA5A51234, 4'hF,    2'b00, 2'b00, 32'h0,        32'h0,        32'hA5A51234, 0, 0, 2);
        vecs[1]  = mk(1, 16'h0504, 32'h0,        4'h0,    2'b00, 2'b00, 32'h0,        32'h0,        32'hA5A51234, 0, 0, 4);
        vecs[2]  = mk(1, 16'h0504, 32'h0,        4'h0,    2'b10, 2'b00, 32'h0,        32'h0,        32'hA5A51234, 1, 0, 4);
        vecs[3]  = mk(1, 16'h0504, 32'h0,        4'h0,    2'b00, 2'b11, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 0, 1, 3);
        vecs[4]  = mk(1, 16'h0506, 32'h0,        4'h0,    2'b00, 2'b00, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 4);
        vecs[5]  = mk(0, 16'h0504, 32'hA5A51234, 4'hF,    2'b00, 2'b00, 32'h0,        32'h0,        32'hA5A51234, 0, 0, 2);
        vecs[6]  = mk(0, 16'h0504, 32'hCAFEF00D, 4'b0011, 2'b00, 2'b00, 32'h0,        32'h0,        32'hA5A5F00D, 0, 0, 2);
        vecs[7]  = mk(0, 16'h0504, 32'hFFFFFFFF, 4'b0000, 2'b00, 2'b00, 32'h0,        32'h0,        32'hA5A5F00D, 0, 0, 2);
        vecs[8]  = mk(1, 16'h0008, 32'h0,        4'h0,    2'b01, 2'b01, 32'h12345678, 32'h0,        32'h12345678, 1, 1, 3);
        vecs[9]  = mk(1, 16'h0008, 32'h0,        4'h0,    2'b00, 2'b00, 32'h0,        32'h0,        32'h12345678, 0, 0, 4);
        vecs[10] = mk(0, 16'hFFFC, 32'h0BADF00D, 4'b1100, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0BAD0000, 0, 0, 2);
        vecs[11] = mk(1, 16'hFFFF, 32'h0,        4'h0,    2'b00, 2'b00, 32'h0,        32'h0,        32'h0BAD0000, 0, 0, 4);

        // 0xFFFC starts unknown; clear it before the partial write in vecs[10]
        do_txn(mk(0, 16'hFFFC, 32'h0, 4'hF, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 2));
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i]);
        end

        // write blocks the bus for two cycles; a competing request in that window is dropped
        do_txn(vecs[5]);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_read   = 1'b0;
        bus.req_addr   = 16'h0504;
        bus.req_wdata  = 32'hCAFEF00D;
        bus.req_byteen = 4'b0011;
        wait_ready();
        e.data = 32'hA5A5F00D; e.sh = 1'b0; e.src = 1'b0; e.at = cyc + 3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_addr   = 16'h0008;
        bus.req_wdata  = 32'h0;
        bus.req_byteen = 4'hF;
        @(negedge clk);
        check_bit("write_busy_ready_c1", bus.req_ready, 1'b0);
        @(negedge clk);
        check_bit("write_busy_ready_c2", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_bit("write_done_ready", bus.req_ready, 1'b1);
        wait_drain();
        do_txn(vecs[9]);

        // reset while the read sits in WAIT abandons it
        do_txn(vecs[5]);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b1;
        bus.req_addr  = 16'h0504;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("midop_reset_ready", bus.req_ready, 1'b1);
        check_bit("midop_reset_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_bit("after_abandon_ready", bus.req_ready, 1'b1);
        do_txn(vecs[1]);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_empty: got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end
endmodule
